// File: rtl/mux_pipe_stage.sv
// mux_pipe_stage: N-way WIDTH-bit operand select with a registered,
// valid/ready flow-controlled output. A main register drives the outputs
// and one skid register absorbs a single beat of backpressure, so in_ready
// is a plain register and never depends combinationally on out_ready.
// Selects of NUM_IN or above deliver zero data with the error flag set.
module mux_pipe_stage #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush
);

  // Channel count widened by one bit so every sel value compares cleanly.
  localparam logic [SEL_W:0] NUM_IN_CMP = (SEL_W+1)'(NUM_IN);

  logic [WIDTH-1:0] chan_s [NUM_IN];

  logic             sel_ok_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             acc_s;
  logic             drn_s;

  logic [WIDTH-1:0] main_data_r, main_data_s;
  logic             main_err_r,  main_err_s;
  logic             main_valid_r, main_valid_s;
  logic [WIDTH-1:0] skid_data_r, skid_data_s;
  logic             skid_err_r,  skid_err_s;
  logic             skid_valid_r, skid_valid_s;
  logic             in_ready_r,  in_ready_s;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_chan
    assign chan_s[k] = in_data[k*WIDTH +: WIDTH];
  end

  assign acc_s = in_valid & in_ready_r;
  assign drn_s = main_valid_r & out_ready;

  // Operand select for the current cycle; out-of-range selects give zero.
  always_comb begin
    sel_ok_s   = ({1'b0, sel} < NUM_IN_CMP);
    sel_data_s = '0;
    if (sel_ok_s) begin
      sel_data_s = chan_s[sel];
    end else begin
      sel_data_s = '0;
    end
  end

  // Next-state for main/skid storage: flush first, then occupancy-driven moves.
  always_comb begin
    main_data_s  = main_data_r;
    main_err_s   = main_err_r;
    main_valid_s = main_valid_r;
    skid_data_s  = skid_data_r;
    skid_err_s   = skid_err_r;
    skid_valid_s = skid_valid_r;
    in_ready_s   = in_ready_r;
    if (flush) begin
      main_valid_s = 1'b0;
      skid_valid_s = 1'b0;
      in_ready_s   = 1'b1;
    end else begin
      case ({main_valid_r, skid_valid_r})
        2'b00: begin
          if (acc_s) begin
            main_data_s  = sel_data_s;
            main_err_s   = ~sel_ok_s;
            main_valid_s = 1'b1;
          end else begin
            main_valid_s = 1'b0;
          end
        end
        2'b10: begin
          if (acc_s && drn_s) begin
            main_data_s = sel_data_s;
            main_err_s  = ~sel_ok_s;
          end else if (acc_s) begin
            skid_data_s  = sel_data_s;
            skid_err_s   = ~sel_ok_s;
            skid_valid_s = 1'b1;
            in_ready_s   = 1'b0;
          end else if (drn_s) begin
            main_valid_s = 1'b0;
          end else begin
            main_valid_s = 1'b1;
          end
        end
        2'b11: begin
          if (drn_s) begin
            main_data_s  = skid_data_r;
            main_err_s   = skid_err_r;
            skid_valid_s = 1'b0;
            in_ready_s   = 1'b1;
          end else begin
            skid_valid_s = 1'b1;
          end
        end
        default: begin
          // Skid full with main empty cannot occur; recover to empty.
          main_valid_s = 1'b0;
          skid_valid_s = 1'b0;
          in_ready_s   = 1'b1;
        end
      endcase
    end
  end

  // State registers with asynchronous clear to the empty stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_r  <= '0;
      main_err_r   <= 1'b0;
      main_valid_r <= 1'b0;
      skid_data_r  <= '0;
      skid_err_r   <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      main_data_r  <= main_data_s;
      main_err_r   <= main_err_s;
      main_valid_r <= main_valid_s;
      skid_data_r  <= skid_data_s;
      skid_err_r   <= skid_err_s;
      skid_valid_r <= skid_valid_s;
      in_ready_r   <= in_ready_s;
    end
  end

  assign out_data  = main_data_r;
  assign out_err   = main_err_r;
  assign out_valid = main_valid_r;
  assign in_ready  = in_ready_r;

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Directed bench for mux_pipe_stage: a 4x32 instance for streaming,
// backpressure, flush and reset cases, and a 5x8 instance for out-of-range
// selects plus a long pseudo-random run checked against a queue model.
module tb_mux_pipe_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // 4-channel, 32-bit instance
  logic [127:0] d4 = '0;
  logic [1:0]   sel4 = 2'd0;
  logic         iv4 = 1'b0, ir4, ov4, oe4, ordy4 = 1'b0, fl4 = 1'b0;
  logic [31:0]  od4;

  // 5-channel, 8-bit instance
  logic [39:0]  d5 = '0;
  logic [2:0]   sel5 = 3'd0;
  logic         iv5 = 1'b0, ir5, ov5, oe5, ordy5 = 1'b0, fl5 = 1'b0;
  logic [7:0]   od5;

  mux_pipe_stage #(.WIDTH(32), .NUM_IN(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .sel(sel4), .in_valid(iv4),
    .in_ready(ir4), .out_data(od4), .out_err(oe4), .out_valid(ov4),
    .out_ready(ordy4), .flush(fl4));

  mux_pipe_stage #(.WIDTH(8), .NUM_IN(5)) u5 (
    .clk(clk), .rst_n(rst_n), .in_data(d5), .sel(sel5), .in_valid(iv5),
    .in_ready(ir5), .out_data(od5), .out_err(oe5), .out_valid(ov5),
    .out_ready(ordy5), .flush(fl5));

  int tests = 0;
  int fails = 0;

  logic [31:0] ch4 [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [7:0]  ch5 [5] = '{8'h15, 8'h25, 8'h35, 8'h45, 8'h55};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model of the 5x8 instance: entries are {err, data}
  logic [8:0] q [$];
  logic [8:0] ent;
  logic       rv, ro, rf;
  logic [2:0] rs;

  initial begin
    // Asynchronous reset, observed before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_ov", ov4, 1'b0);
    check("rst_od", od4, 32'h0);
    check("rst_oe", oe4, 1'b0);
    check("rst_ir", ir4, 1'b1);
    check("rst_ov5", ov5, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) d4[k*32 +: 32] = ch4[k];
    for (int k = 0; k < 5; k++) d5[k*8 +: 8] = ch5[k];

    // Streaming, one entry per cycle
    ordy4 = 1'b1;
    for (int s = 0; s < 4; s++) begin
      iv4 = 1'b1;
      sel4 = 2'(s);
      step();
      check("stream_ov", ov4, 1'b1);
      check("stream_od", od4, ch4[s]);
      check("stream_oe", oe4, 1'b0);
      check("stream_ir", ir4, 1'b1);
    end
    iv4 = 1'b0;
    step();
    check("stream_drained", ov4, 1'b0);

    // Backpressure: A (sel 1) then B (sel 2) with downstream stalled
    ordy4 = 1'b0;
    iv4 = 1'b1; sel4 = 2'd1;
    step();
    check("bp_a_ov", ov4, 1'b1);
    check("bp_a_od", od4, 32'h22222222);
    check("bp_a_ir", ir4, 1'b1);
    sel4 = 2'd2;
    step();
    check("bp_b_ir", ir4, 1'b0);
    check("bp_b_od", od4, 32'h22222222);
    sel4 = 2'd3;            // offered while full: must not be taken
    step();
    check("bp_hold_ir", ir4, 1'b0);
    check("bp_hold_od", od4, 32'h22222222);
    check("bp_hold_ov", ov4, 1'b1);
    iv4 = 1'b0; ordy4 = 1'b1;
    step();
    check("bp_deliver_b", od4, 32'h33333333);
    check("bp_deliver_ov", ov4, 1'b1);
    check("bp_ir_back", ir4, 1'b1);
    step();
    check("bp_empty", ov4, 1'b0);
    step();
    check("bp_no_extra", ov4, 1'b0);

    // Flush collision at occupancy 2
    ordy4 = 1'b0; iv4 = 1'b1; sel4 = 2'd0;
    step();
    sel4 = 2'd1;
    step();
    check("fl_full_ir", ir4, 1'b0);
    fl4 = 1'b1; ordy4 = 1'b1; sel4 = 2'd3;
    step();
    check("fl_ov", ov4, 1'b0);
    check("fl_ir", ir4, 1'b1);
    fl4 = 1'b0; iv4 = 1'b0;
    step();
    check("fl_after1", ov4, 1'b0);
    step();
    check("fl_after2", ov4, 1'b0);

    // Reset mid-transfer, then first accept right after release
    ordy4 = 1'b0; iv4 = 1'b1; sel4 = 2'd2;
    step();
    check("mr_loaded", ov4, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_ov", ov4, 1'b0);
    check("mr_od", od4, 32'h0);
    check("mr_ir", ir4, 1'b1);
    #1 rst_n = 1'b1;
    sel4 = 2'd3;
    step();
    check("mr_first_ov", ov4, 1'b1);
    check("mr_first_od", od4, 32'h44444444);
    iv4 = 1'b0; ordy4 = 1'b1;
    step();

    // Out-of-range selects on the 5-channel instance
    ordy5 = 1'b1; iv5 = 1'b1; sel5 = 3'd5;
    step();
    check("oor5_ov", ov5, 1'b1);
    check("oor5_od", od5, 8'h00);
    check("oor5_oe", oe5, 1'b1);
    sel5 = 3'd7;
    step();
    check("oor7_od", od5, 8'h00);
    check("oor7_oe", oe5, 1'b1);
    sel5 = 3'd4;
    step();
    check("sel4_od", od5, 8'h55);
    check("sel4_oe", oe5, 1'b0);
    sel5 = 3'd0;
    step();
    check("sel0_od", od5, 8'h15);
    check("sel0_oe", oe5, 1'b0);
    iv5 = 1'b0;
    step();
    check("oor_drained", ov5, 1'b0);

    // Pseudo-random traffic against a FIFO model
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      rv = ($urandom_range(0, 3) != 0);
      ro = ($urandom_range(0, 2) != 0);
      rf = ($urandom_range(0, 39) == 0);
      rs = 3'($urandom_range(0, 7));
      iv5 = rv; ordy5 = ro; fl5 = rf; sel5 = rs;
      #1;
      check("rnd_ir_pre", ir5, (q.size() < 2) ? 1'b1 : 1'b0);
      @(posedge clk);
      if (rf) begin
        q.delete();
      end else begin
        logic acc, drn;
        acc = rv && (q.size() < 2);
        drn = ro && (q.size() > 0);
        if (drn) void'(q.pop_front());
        if (acc) begin
          ent = (rs < 3'd5) ? {1'b0, ch5[rs]} : 9'h100;
          q.push_back(ent);
        end
      end
      #1;
      check("rnd_ov", ov5, (q.size() > 0) ? 1'b1 : 1'b0);
      check("rnd_ir", ir5, (q.size() < 2) ? 1'b1 : 1'b0);
      if (q.size() > 0) check("rnd_head", {oe5, od5}, q[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
